nibble_serial_subtractor: RTL
=============================

Name: nibble_serial_subtractor

Overview:
- Multi-cycle, nibble-serial subtractor: computes diff = x - y - bin for WIDTH-bit operands, 4 bits per clock, LSB nibble first.
- Contains one internal 4-bit borrow-ripple slice and a registered borrow chaining the slices across cycles.
- Sits between a valid/ready operand source and a valid/ready result consumer.
- Used where a WIDTH-wide combinational borrow chain is too long or too large.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived local count of slice iterations; not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand set presented
- in_ready  output  1  block accepts operands this cycle
- x  input  WIDTH  minuend
- y  input  WIDTH  subtrahend
- bin  input  1  borrow-in to LSB nibble
- out_valid  output  1  result held on diff/bout
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  x - y - bin, modulo 2^WIDTH
- bout  output  1  borrow-out of MSB; 1 when unsigned x < y + bin

Behaviour:
- One clock, rst synchronous active-high, sampled on the rising clk edge.
- Reset values:
  - state = IDLE, out_valid = 0, in_ready = 1.
  - diff = 0, bout = 0.
  - Internal operand/borrow/counter registers = 0.
- States: IDLE, RUN, DONE. in_ready = (state == IDLE); out_valid = (state == DONE). Both are decoded from registered state only, with no combinational input-to-output paths.
- IDLE:
  - On the edge where in_valid && in_ready, capture x, y and bin into internal registers; cnt = 0; go to RUN.
- RUN:
  - Each cycle, the slice processes nibble cnt of the captured operands with the borrow register.
  - Per bit: d = a ^ b ^ br; br_next = (~a & b) | ((~a | b) & br).
  - The 4-bit result is written to diff[4*cnt+3 : 4*cnt]. The borrow register takes the slice borrow-out, and cnt increments.
  - When cnt == NIBBLES-1, this edge also loads bout with the slice borrow-out and moves to DONE.
- DONE:
  - diff, bout and out_valid hold stable until out_ready = 1; on that edge go to IDLE.
  - diff and bout keep their last value after leaving DONE until the next computation overwrites them.
- Latency: out_valid rises exactly NIBBLES clock edges after the accept edge (WIDTH = 16 gives 4).
- Issue interval: NIBBLES + 2 cycles minimum (accept, NIBBLES computes, 1 handshake cycle back to IDLE).
- Boundary conditions:
  - in_valid while in RUN or DONE is ignored; the operands are not captured.
  - The x/y/bin inputs may change freely after the accept edge.
  - out_ready while not in DONE has no effect.
  - rst asserted in any state (including mid-RUN) aborts the operation and returns to the reset values next edge. No partial result is flagged valid.
  - Wrap-around: the result is modulo 2^WIDTH; the unsigned underflow is reported only through bout.
  - WIDTH = 4 degenerates to a single RUN cycle.

Optional Feature:
- Macro: NIBBLE_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), reset 0, loaded on the same edge as bout.
  - ovf = two's-complement signed overflow of x - y - bin: (x[MSB] != y[MSB]) && (diff[MSB] != x[MSB]).
  - Evaluated on the captured operands and the final MSB nibble.
  - Held with out_valid like bout.
- Undefined: no ovf port, no related logic; the port list is otherwise identical.

Test Plan:
- WIDTH = 16, x = 0x1234, y = 0x0234, bin = 0:
  - Accept at edge T, out_valid at T+4.
  - diff = 0x1000, bout = 0.
  - in_ready low from T until the edge after out_ready.
- x = 0x0000, y = 0x0001, bin = 0 gives diff = 0xFFFF, bout = 1.
- x = 0x5555, y = 0x5555, bin = 1 gives diff = 0xFFFF, bout = 1.
- x = 0xF00F, y = 0x0FF0, bin = 0 gives diff = 0xE01F, bout = 0.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid.
  - diff/bout/out_valid stay constant.
  - in_valid pulses during RUN/DONE are not captured.
  - Once out_ready = 1, the next operand set is accepted 1 cycle later and produces the correct result.
- Reset mid-RUN: assert rst at the 2nd RUN edge.
  - Next cycle: in_ready = 1, out_valid = 0, diff = 0, bout = 0.
  - A fresh operation then completes correctly.
- With NIBBLE_SUB_OVF_EN: x = 0x8000, y = 0x0001, bin = 0 gives diff = 0x7FFF, ovf = 1, bout = 0. x = 0x0003, y = 0x0001 gives ovf = 0.

Source files
------------

// File: rtl/nibble_serial_subtractor.sv
// Nibble-serial subtractor: diff = x - y - bin, one 4-bit borrow-ripple slice per clock, LSB first.
// Optional NIBBLE_SUB_OVF_EN adds a registered signed-overflow flag (ovf) loaded with bout.

module nss_bit_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_br,
  output logic o_d,
  output logic o_br
);
  assign o_d  = i_a ^ i_b ^ i_br;
  assign o_br = (~i_a & i_b) | ((~i_a | i_b) & i_br);
endmodule

module nss_slice (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_br,
  output logic [3:0] o_d,
  output logic       o_br
);
  logic [4:0] w_chain;

  assign w_chain[0] = i_br;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_bit
      nss_bit_cell u_cell (
        .i_a  (i_a[g]),
        .i_b  (i_b[g]),
        .i_br (w_chain[g]),
        .o_d  (o_d[g]),
        .o_br (w_chain[g+1])
      );
    end
  endgenerate

  assign o_br = w_chain[4];
endmodule

module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef NIBBLE_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
`ifdef NIBBLE_SUB_OVF_EN
  logic             r_ovf;
`endif

  logic [3:0]    w_a;
  logic [3:0]    w_b;
  logic [3:0]    w_d;
  logic          w_bo;
  logic [CW+1:0] w_base;
  logic          w_last;

  // Nibble base index is cnt*4, built by concatenation to keep the select width exact.
  assign w_base = {r_cnt, 2'b00};
  assign w_a    = r_x[w_base +: 4];
  assign w_b    = r_y[w_base +: 4];
  assign w_last = (r_cnt == CW'(NIBBLES - 1));

  nss_slice u_slice (
    .i_a  (w_a),
    .i_b  (w_b),
    .i_br (r_br),
    .o_d  (w_d),
    .o_br (w_bo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_br        <= 1'b0;
      r_cnt       <= '0;
      r_diff      <= '0;
      r_bout      <= 1'b0;
`ifdef NIBBLE_SUB_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x        <= x;
            r_y        <= y;
            r_br       <= bin;
            r_cnt      <= '0;
            r_state    <= S_RUN;
            r_in_ready <= 1'b0;
          end
        end
        S_RUN: begin
          r_diff[w_base +: 4] <= w_d;
          r_br                <= w_bo;
          r_cnt               <= r_cnt + 1'b1;
          if (w_last) begin
            r_bout      <= w_bo;
`ifdef NIBBLE_SUB_OVF_EN
            // Signed overflow: operand signs differ and the result sign departs from x.
            r_ovf       <= (r_x[WIDTH-1] != r_y[WIDTH-1]) && (w_d[3] != r_x[WIDTH-1]);
`endif
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign bout      = r_bout;
`ifdef NIBBLE_SUB_OVF_EN
  assign ovf       = r_ovf;
`endif

endmodule
